// File: rtl/linebuffer_scheduler_pkg.sv
// Shared types for the line-buffer scheduler: FSM state encoding and padding modes.
package linebuffer_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_LOAD,
    ST_SETTLE,
    ST_COMPUTE,
    ST_DONE
  } lb_state_e;

  localparam logic PADDING_VALID = 1'b0;
  localparam logic PADDING_SAME  = 1'b1;

endpackage

// File: rtl/linebuffer_scheduler_counter.sv
// Up-counter with synchronous clear to an init value, step enable and a
// "next step reaches limit" flag; one extra internal bit keeps the compare exact.
module linebuffer_scheduler_counter #(
  parameter int WIDTH = 6,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] init,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] value,
  output logic             last
);

  localparam logic [WIDTH:0] INC = (WIDTH + 1)'(STEP);

  logic [WIDTH:0] next_value;

  assign next_value = {1'b0, value} + INC;
  assign last       = next_value >= {1'b0, limit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= init;
    end else if (enable) begin
      value <= next_value[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/linebuffer_scheduler.sv
// Sequences line-buffer fetch/write and KxK window reads for one layer, with
// SAME/VALID padding; each output row is preceded by just enough row loads.
module linebuffer_scheduler
  import linebuffer_scheduler_pkg::*;
#(
  parameter int K                 = 3,
  parameter int IMAGEWIDTH        = 32,
  parameter int IMAGEHEIGHT       = 32,
  parameter int COLADDRESSWIDTH   = $clog2(IMAGEWIDTH),
  parameter int ROWADDRESSWIDTH   = $clog2(IMAGEHEIGHT),
  parameter int TBROWADDRESSWIDTH = $clog2(K)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic                         padding_same_i,
  input  logic [COLADDRESSWIDTH:0]     layer_imagewidth_i,
  input  logic [ROWADDRESSWIDTH:0]     layer_imageheight_i,
  output logic                         fetch_valid_o,
  input  logic                         fetch_ready_i,
  output logic [ROWADDRESSWIDTH-1:0]   fetch_row_o,
  output logic [COLADDRESSWIDTH-1:0]   fetch_col_o,
  output logic                         lb_flush_o,
  output logic                         lb_write_enable_o,
  output logic                         lb_wrap_around_save_enable_o,
  output logic                         lb_read_enable_o,
  output logic [COLADDRESSWIDTH-1:0]   lb_write_col_o,
  output logic [COLADDRESSWIDTH-1:0]   lb_read_col_o,
  output logic [TBROWADDRESSWIDTH-1:0] lb_read_row_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int CW   = COLADDRESSWIDTH + 1;
  localparam int RW   = ROWADDRESSWIDTH + 1;
  localparam int HALF = (K - 1) / 2;

  localparam logic [CW-1:0] HALF_COL  = CW'(HALF);
  localparam logic [RW-1:0] KM1_ROW   = RW'(K - 1);
  localparam logic [RW:0]   ONE_ROW   = (RW + 1)'(1);
  localparam logic [RW:0]   HALF_ROW  = (RW + 1)'(HALF);
  localparam logic [RW:0]   K_ROW     = (RW + 1)'(K);
  localparam logic [RW:0]   PRE_SAME  = (RW + 1)'(HALF + 1);
  localparam logic [RW:0]   PRE_VALID = (RW + 1)'(K);

  lb_state_e state_q, state_d;

  logic [CW-1:0] width_q;
  logic [RW-1:0] height_q;
  logic          same_q;

  logic          start_layer, fetch_hs, out_hs;
  logic [CW-1:0] load_col, read_col, read_col_init, read_col_limit;
  logic [RW-1:0] load_row, out_row, out_row_limit;
  logic          load_col_last, load_row_last, read_col_last, out_row_last;
  logic [RW:0]   need_rows;
  logic          preload_met, rows_remain, bottom_row;
  logic          unused_msbs;

  assign start_layer = (state_q == ST_IDLE) && start_i;
  assign fetch_hs    = fetch_valid_o && fetch_ready_i;
  assign out_hs      = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      width_q  <= '0;
      height_q <= '0;
      same_q   <= PADDING_VALID;
    end else if (start_layer) begin
      width_q  <= layer_imagewidth_i;
      height_q <= layer_imageheight_i;
      same_q   <= padding_same_i;
    end
  end

  // The read column is re-armed at layer start, before the config is latched.
  assign read_col_init  = (((state_q == ST_IDLE) ? padding_same_i : same_q) == PADDING_SAME)
                          ? '0 : HALF_COL;
  assign read_col_limit = (same_q == PADDING_SAME) ? width_q : width_q - HALF_COL;
  assign out_row_limit  = (same_q == PADDING_SAME) ? height_q : height_q - KM1_ROW;

  // Rows that must be resident before output row out_row can be computed.
  assign need_rows   = {1'b0, out_row} + ((same_q == PADDING_SAME) ? PRE_SAME : PRE_VALID);
  assign preload_met = (({1'b0, load_row} + ONE_ROW) >= need_rows) || load_row_last;
  assign rows_remain = load_row < height_q;
  assign bottom_row  = (same_q == PADDING_SAME) && (({1'b0, out_row} + HALF_ROW) >= {1'b0, height_q});

  linebuffer_scheduler_counter #(.WIDTH(CW), .STEP(K)) u_load_col (
    .clk(clk_i), .rst_n(rst_ni),
    .clear(start_layer || (fetch_hs && load_col_last)), .enable(fetch_hs),
    .init('0), .limit(width_q), .value(load_col), .last(load_col_last)
  );

  linebuffer_scheduler_counter #(.WIDTH(RW), .STEP(1)) u_load_row (
    .clk(clk_i), .rst_n(rst_ni),
    .clear(start_layer), .enable(fetch_hs && load_col_last),
    .init('0), .limit(height_q), .value(load_row), .last(load_row_last)
  );

  linebuffer_scheduler_counter #(.WIDTH(CW), .STEP(1)) u_read_col (
    .clk(clk_i), .rst_n(rst_ni),
    .clear(start_layer || (out_hs && read_col_last)), .enable(out_hs),
    .init(read_col_init), .limit(read_col_limit), .value(read_col), .last(read_col_last)
  );

  linebuffer_scheduler_counter #(.WIDTH(RW), .STEP(1)) u_out_row (
    .clk(clk_i), .rst_n(rst_ni),
    .clear(start_layer), .enable(out_hs && read_col_last),
    .init('0), .limit(out_row_limit), .value(out_row), .last(out_row_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    fetch_valid_o    = 1'b0;
    lb_flush_o       = 1'b0;
    out_valid_o      = 1'b0;
    lb_read_enable_o = 1'b0;
    busy_o           = 1'b1;
    done_o           = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        lb_flush_o = 1'b1;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        fetch_valid_o = 1'b1;
        if (fetch_valid_o && fetch_ready_i && load_col_last && preload_met) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        out_valid_o      = 1'b1;
        lb_read_enable_o = 1'b1;
        if (out_ready_i && read_col_last) begin
          if (out_row_last)     state_d = ST_DONE;
          else if (rows_remain) state_d = ST_LOAD;
          else                  state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fetch_row_o                  = load_row[ROWADDRESSWIDTH-1:0];
  assign fetch_col_o                  = load_col[COLADDRESSWIDTH-1:0];
  assign lb_write_enable_o            = fetch_hs;
  assign lb_write_col_o               = load_col[COLADDRESSWIDTH-1:0];
  assign lb_wrap_around_save_enable_o = 1'b0;
  assign lb_read_col_o                = out_valid_o ? read_col[COLADDRESSWIDTH-1:0] : '0;
  assign lb_read_row_o                = !out_valid_o ? '0 :
                                        bottom_row ? TBROWADDRESSWIDTH'({1'b0, out_row} + K_ROW - {1'b0, height_q})
                                                   : TBROWADDRESSWIDTH'(HALF);

  // Column counters never exceed W-1 when observed, so their top bit is not needed outside.
  assign unused_msbs = load_col[CW-1] ^ read_col[CW-1];

endmodule
